// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I load or store at a time, checks funct3
// and alignment, runs a single bounded memory access and returns one
// response pulse carrying the extended load data or an error code.
//
// Handshakes: the core side is valid/ready. A request transfers on a rising
// edge where req_valid and req_ready are both 1, and req_ready is 1 only
// while idle. The memory side is req/ack. mem_req stays high, with address,
// lanes and data held stable, until mem_ack is sampled high or the wait
// limit runs out. rsp_valid is a single-cycle pulse and has no ready.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_FUNCT3  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    state_t        state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]    rsp_err_q, rsp_err_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    lane_q, lane_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          req_illegal;
    logic          req_misaligned;
    logic [3:0]    req_be;
    logic [31:0]   req_lane_wdata;
    logic [31:0]   lane_word;
    logic [31:0]   load_ext;

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

    // Decode the incoming request: legality, alignment, lanes and store data.
    always_comb begin
        req_illegal    = 1'b1;
        req_misaligned = 1'b0;
        req_be         = 4'b0000;
        req_lane_wdata = 32'd0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
            3'b100, 3'b101:         req_illegal = req_we;
            default:                req_illegal = 1'b1;
        endcase
        case (req_funct3[1:0])
            2'b00: begin
                req_be         = 4'b0001 << req_addr[1:0];
                req_lane_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_misaligned = req_addr[0];
                req_be         = req_addr[1] ? 4'b1100 : 4'b0011;
                req_lane_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                req_misaligned = (req_addr[1:0] != 2'b00);
                req_be         = 4'b1111;
                req_lane_wdata = req_wdata;
            end
        endcase
        if (!req_we) begin
            req_lane_wdata = 32'd0;
        end
    end

    // Select and extend the addressed lane of the returned word.
    always_comb begin
        lane_word = mem_rdata >> {lane_q, 3'b000};
        load_ext  = 32'd0;
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b010:  load_ext = lane_word;
            3'b100:  load_ext = {24'd0, lane_word[7:0]};
            3'b101:  load_ext = {16'd0, lane_word[15:0]};
            default: load_ext = 32'd0;
        endcase
    end

    // Next-state and registered-output logic of the IDLE/ACCESS/RESP FSM.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    funct3_d    = req_funct3;
                    lane_d      = req_addr[1:0];
                    if (req_illegal) begin
                        // Illegal funct3 is reported ahead of misalignment.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = ERR_FUNCT3;
                        rsp_rdata_d = 32'd0;
                    end else if (req_misaligned) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = ERR_ALIGN;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_lane_wdata;
                        cnt_d       = '0;
                    end
                end
            end
            ACCESS: begin
                // An ack on the expiry edge still completes normally.
                if (mem_ack) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_OK;
                    rsp_rdata_d = mem_we_q ? 32'd0 : load_ext;
                    cnt_d       = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_TIMEOUT;
                    rsp_rdata_d = 32'd0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                mem_req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            funct3_q    <= 3'd0;
            lane_q      <= 2'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus randomized
// transactions checked against a byte-level reference model.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks;
    int errors;
    logic ack_noise;

    // observations of the last transaction
    int          o_mreq;
    int          o_lat;
    logic        o_stable;
    logic        o_ready_before;
    logic [31:0] o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wdata;
    logic        o_we;
    logic [31:0] o_rdata;
    logic [1:0]  o_err;
    logic        o_after_valid;
    logic        o_after_ready;
    logic        o_hold;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic [2:0] f3);
        int code;
        code = int'(f3) % 4;
        return (code == 0) ? 1 : (code == 1) ? 2 : 4;
    endfunction

    function automatic logic [1:0] ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        if (we) legal = (f3 == 0 || f3 == 1 || f3 == 2);
        else    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        if (!legal) return 2'b10;
        if ((a % ref_size(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        int mask;
        sz = ref_size(f3);
        mask = ((1 << sz) - 1) << (a % 4);
        return 4'(mask);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic we, input logic [2:0] f3, input logic [31:0] w);
        int sz;
        if (!we) return 32'd0;
        sz = ref_size(f3);
        if (sz == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ref_rdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        int sz;
        sz = ref_size(f3);
        v = rd >> (8 * (a % 4));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (f3 < 4 && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (f3 < 4 && v >= 32768) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1 with the DUT idle; returns at posedge+1.
    // ack_after: mem_ack is presented on the n-th cycle mem_req is seen
    // high (n = ack_after); values never reached mean ack is withheld.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_after, input logic [31:0] rdata);
        bit seen;
        o_mreq = 0; o_lat = -1; o_stable = 1'b1;
        o_addr = 32'd0; o_be = 4'd0; o_wdata = 32'd0; o_we = 1'b0;
        o_rdata = 32'd0; o_err = 2'b00;
        o_ready_before = req_ready;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        seen = 0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            if (mem_req) begin
                if (o_mreq == 0) begin
                    o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
                end else if (mem_addr !== o_addr || mem_be !== o_be ||
                             mem_wdata !== o_wdata || mem_we !== o_we) begin
                    o_stable = 1'b0;
                end
                o_mreq++;
            end
            if (rsp_valid) begin
                seen = 1;
                o_lat = cyc;
                o_rdata = rsp_rdata;
                o_err = rsp_err;
            end
            if (mem_req) mem_ack = (o_mreq == ack_after);
            else         mem_ack = ack_noise & 1'($urandom);
            mem_rdata = mem_ack ? rdata : $urandom;
        end
        @(negedge clk);
        o_after_valid = rsp_valid;
        o_after_ready = req_ready;
        o_hold = (rsp_rdata === o_rdata) && (rsp_err === o_err);
        mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hs: ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
        end
        checks++;
        if (rsp_rdata !== 32'd0 || rsp_err !== 2'b00) begin
            errors++; $display("FAIL reset_rsp: rdata=%h err=%b expected 0 00", rsp_rdata, rsp_err);
        end
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 ||
            mem_be !== 4'd0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL reset_mem: req=%b we=%b addr=%h be=%b wdata=%h expected all 0",
                               mem_req, mem_we, mem_addr, mem_be, mem_wdata);
        end
    endtask

    task automatic test_lb;
        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_1234);
        checks++;
        if (o_addr !== 32'h100 || o_be !== 4'b1000 || o_we !== 1'b0 || o_wdata !== 32'd0) begin
            errors++; $display("FAIL lb_mem: addr=%h be=%b we=%b wdata=%h expected 100 1000 0 0",
                               o_addr, o_be, o_we, o_wdata);
        end
        checks++;
        if (o_rdata !== 32'hFFFF_FF80 || o_err !== 2'b00) begin
            errors++; $display("FAIL lb_rsp: rdata=%h err=%b expected ffffff80 00", o_rdata, o_err);
        end
        checks++;
        if (o_lat !== 2 || o_mreq !== 1) begin
            errors++; $display("FAIL lb_latency: lat=%0d mreq=%0d expected 2 1", o_lat, o_mreq);
        end
        checks++;
        if (o_after_valid !== 1'b0 || o_after_ready !== 1'b1 || o_hold !== 1'b1) begin
            errors++; $display("FAIL lb_after: valid=%b ready=%b hold=%b expected 0 1 1",
                               o_after_valid, o_after_ready, o_hold);
        end
    endtask

    task automatic test_sh;
        run_txn(1'b1, 3'b001, 32'h22, 32'h0000_ABCD, 2, $urandom);
        checks++;
        if (o_be !== 4'b1100 || o_wdata !== 32'hABCD_ABCD || o_we !== 1'b1 || o_addr !== 32'h20) begin
            errors++; $display("FAIL sh_mem: be=%b wdata=%h we=%b addr=%h expected 1100 abcdabcd 1 20",
                               o_be, o_wdata, o_we, o_addr);
        end
        checks++;
        if (o_rdata !== 32'd0 || o_err !== 2'b00 || o_lat !== 3 || o_stable !== 1'b1) begin
            errors++; $display("FAIL sh_rsp: rdata=%h err=%b lat=%0d stable=%b expected 0 00 3 1",
                               o_rdata, o_err, o_lat, o_stable);
        end
    endtask

    task automatic test_misaligned;
        run_txn(1'b0, 3'b010, 32'h41, 32'h0, 1, $urandom);
        checks++;
        if (o_mreq !== 0 || o_lat !== 1 || o_err !== 2'b01 || o_rdata !== 32'd0) begin
            errors++; $display("FAIL misaligned: mreq=%0d lat=%0d err=%b rdata=%h expected 0 1 01 0",
                               o_mreq, o_lat, o_err, o_rdata);
        end
    endtask

    task automatic test_illegal;
        run_txn(1'b1, 3'b100, 32'h40, $urandom, 1, $urandom);
        checks++;
        if (o_mreq !== 0 || o_lat !== 1 || o_err !== 2'b10 || o_rdata !== 32'd0) begin
            errors++; $display("FAIL illegal_store: mreq=%0d lat=%0d err=%b rdata=%h expected 0 1 10 0",
                               o_mreq, o_lat, o_err, o_rdata);
        end
        run_txn(1'b0, 3'b011, 32'h43, 32'h0, 1, $urandom);
        checks++;
        if (o_mreq !== 0 || o_err !== 2'b10) begin
            errors++; $display("FAIL illegal_priority: mreq=%0d err=%b expected 0 10", o_mreq, o_err);
        end
    endtask

    task automatic test_timeout;
        run_txn(1'b0, 3'b101, 32'h2, 32'h0, -1, $urandom);
        checks++;
        if (o_mreq !== TO || o_err !== 2'b11 || o_lat !== TO + 1 || o_rdata !== 32'd0) begin
            errors++; $display("FAIL timeout: mreq=%0d err=%b lat=%0d rdata=%h expected %0d 11 %0d 0",
                               o_mreq, o_err, o_lat, o_rdata, TO, TO + 1);
        end
        // a late ack must do nothing
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
                errors++; $display("FAIL late_ack: valid=%b mreq=%b ready=%b expected 0 0 1",
                                   rsp_valid, mem_req, req_ready);
            end
        end
        mem_ack = 1'b0;
        @(posedge clk); #1;
        // ack on the expiry edge completes normally
        run_txn(1'b0, 3'b101, 32'h2, 32'h0, TO, 32'hBEEF_1234);
        checks++;
        if (o_mreq !== TO || o_err !== 2'b00 || o_rdata !== 32'h0000_BEEF || o_lat !== TO + 1) begin
            errors++; $display("FAIL ack_at_expiry: mreq=%0d err=%b rdata=%h lat=%0d expected %0d 00 0000beef %0d",
                               o_mreq, o_err, o_rdata, o_lat, TO, TO + 1);
        end
    endtask

    task automatic test_reset_in_access;
        bit bad;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL rst_pre: mreq=%b expected 1", mem_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
            mem_addr !== 32'd0 || mem_be !== 4'd0) begin
            errors++; $display("FAIL rst_async: mreq=%b ready=%b valid=%b addr=%h be=%b expected 0 1 0 0 0",
                               mem_req, req_ready, rsp_valid, mem_addr, mem_be);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) bad = 1;
        end
        mem_ack = 1'b0;
        checks++;
        if (bad) begin
            errors++; $display("FAIL rst_after: unexpected response or request after reset");
        end
        @(posedge clk); #1;
        run_txn(1'b1, 3'b010, 32'h84, 32'h1234_5678, 1, $urandom);
        checks++;
        if (o_err !== 2'b00 || o_wdata !== 32'h1234_5678 || o_be !== 4'b1111 || o_lat !== 2) begin
            errors++; $display("FAIL rst_recover: err=%b wdata=%h be=%b lat=%0d expected 00 12345678 1111 2",
                               o_err, o_wdata, o_be, o_lat);
        end
    endtask

    task automatic test_random;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata, e_rdata;
        logic [1:0]  e_err;
        int          ack_after, e_mreq;
        ack_noise = 1'b1;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom); f3 = 3'($urandom);
            addr = $urandom; wdata = $urandom; rdata = $urandom;
            ack_after = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 5);
            e_err = ref_err(we, f3, addr);
            e_rdata = 32'd0;
            e_mreq = 0;
            if (e_err == 2'b00) begin
                if (ack_after > TO) begin
                    e_err = 2'b11; e_mreq = TO;
                end else begin
                    e_mreq = ack_after;
                    if (!we) e_rdata = ref_rdata(f3, addr, rdata);
                end
            end
            run_txn(we, f3, addr, wdata, ack_after, rdata);
            checks++;
            if (o_err !== e_err || o_rdata !== e_rdata || o_ready_before !== 1'b1) begin
                errors++; $display("FAIL rnd_rsp[%0d]: we=%b f3=%b addr=%h err=%b rdata=%h ready=%b expected %b %h 1",
                                   n, we, f3, addr, o_err, o_rdata, o_ready_before, e_err, e_rdata);
            end
            checks++;
            if (o_mreq !== e_mreq || o_lat !== e_mreq + 1 || o_after_valid !== 1'b0 || o_hold !== 1'b1) begin
                errors++; $display("FAIL rnd_timing[%0d]: mreq=%0d lat=%0d after=%b hold=%b expected %0d %0d 0 1",
                                   n, o_mreq, o_lat, o_after_valid, o_hold, e_mreq, e_mreq + 1);
            end
            if (e_mreq != 0) begin
                checks++;
                if (o_addr !== {addr[31:2], 2'b00} || o_be !== ref_be(f3, addr) ||
                    o_wdata !== ref_wdata(we, f3, wdata) || o_we !== we || o_stable !== 1'b1) begin
                    errors++; $display("FAIL rnd_mem[%0d]: addr=%h be=%b wdata=%h we=%b stable=%b expected %h %b %h %b 1",
                                       n, o_addr, o_be, o_wdata, o_we, o_stable,
                                       {addr[31:2], 2'b00}, ref_be(f3, addr), ref_wdata(we, f3, wdata), we);
                end
            end
        end
        ack_noise = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; ack_noise = 1'b0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        #12;
        test_reset;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_lb;
        test_sh;
        test_misaligned;
        test_illegal;
        test_timeout;
        test_reset_in_access;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of cycles mem_req waits for mem_ack before the access aborts.
REQ-002 The block SHALL have these ports, one clock, reset asynchronous active-high:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  core presents a load/store
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data
- rsp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_be  out  4  byte-lane enables
- mem_wdata  out  32  lane-positioned store data
- mem_ack  in  1  memory completes the access this cycle
- mem_rdata  in  32  read word, valid with mem_ack

Function
REQ-003 The FSM SHALL have states IDLE, ACCESS and RESP, and all outputs SHALL be registered.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-005 The block SHALL capture the request fields at acceptance; later changes on req_* SHALL have no effect.
REQ-006 Legal funct3 values SHALL be: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- Any other value -> IDLE to RESP with rsp_err=10, no memory access.
REQ-007 Misalignment SHALL be halfword with addr[0]=1, or word with addr[1:0]!=00.
- Misaligned -> IDLE to RESP with rsp_err=01, no memory access.
- Illegal funct3 SHALL take priority over misalignment.
REQ-008 A legal aligned request SHALL move IDLE to ACCESS; mem_req SHALL be 1 from the next cycle, with mem_addr = {addr[31:2],2'b00} and mem_we = req_we, all stable until mem_ack.
REQ-009 mem_be SHALL be:
- byte access: 4'b0001 << addr[1:0]
- halfword: 0011 (addr[1]=0) or 1100 (addr[1]=1)
- word: 1111
- loads use the same mem_be.
REQ-010 mem_wdata SHALL be:
- SB: wdata[7:0] replicated into all four lanes
- SH: wdata[15:0] replicated into both halves
- SW: wdata unchanged
- loads: 0.
REQ-011 In ACCESS, mem_ack=1 on a rising edge SHALL end the access.
- mem_req drops to 0 the next cycle.
- The state moves to RESP with rsp_err=00.
REQ-012 Load data SHALL be the selected lane of mem_rdata.
- LB/LH sign-extended, LBU/LHU zero-extended, LW the full word.
- Stores and all errors return rsp_rdata=0.
REQ-013 A counter SHALL count ACCESS cycles without mem_ack.
- After TIMEOUT such cycles, mem_req drops and the state moves to RESP with rsp_err=11.
- mem_ack on the same edge as expiry wins: normal completion.
REQ-014 RESP SHALL last exactly one cycle: rsp_valid=1, then return to IDLE with req_ready=1.
- rsp_rdata/rsp_err hold their values until the next response.
REQ-015 Latency: accept at edge N, mem_ack sampled at edge M>=N+1 -> rsp_valid during the cycle after edge M. Error paths: rsp_valid during the cycle after edge N.
REQ-016 mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-017 rst=1 SHALL immediately force state IDLE and the following, regardless of clk:
- req_ready=1
- rsp_valid=0, rsp_rdata=0, rsp_err=00
- mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0
- timeout counter=0
REQ-018 Reset during ACCESS SHALL abandon the access with no response; a mem_ack arriving after reset release is ignored per REQ-016.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- LB addr=0x103, mem_ack next cycle with mem_rdata=0x80FF_1234 -> mem_addr=0x100, mem_be=1000; rsp_rdata=0xFFFF_FF80, rsp_err=00; 2-cycle latency.
- SH addr=0x22, wdata=0x0000_ABCD -> mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1; rsp_rdata=0.
- LW addr=0x41 -> no mem_req; rsp_valid the cycle after acceptance with rsp_err=01.
- Store funct3=100 -> rsp_err=10, no mem_req.
- LHU addr=0x2, mem_ack withheld -> mem_req high exactly 16 cycles; rsp_err=11; a later mem_ack is ignored.
- rst asserted in ACCESS mid-wait -> mem_req=0 at once; req_ready=1; no rsp_valid.
